blackwidow_bus_ram: RTL and testbench



---
 rtl/blackwidow_bus_ram.sv | 171 +++++++++++++++++
 tb/tb_blackwidow_bus_ram.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackwidow_bus_ram.sv
`default_nettype none
// ============================================================================
// Module      : blackwidow_bus_ram
// Description : Burst-capable 128-bit on-chip RAM responding on the BlackWidow
//               external bus. Decodes a base-aligned window and serves classic
//               cycles plus linear / 4-, 8-, 16-beat wrapping bursts.
// Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//               cyc_i, stb_i      - bus cycle valid / beat strobe
//               we_i, sel_i       - write enable / 16 byte-lane enables
//               adr_i             - byte address (bits [3:0] ignored)
//               cti_i, bte_i      - cycle type / burst type
//               dat_i             - write data
//               ack_o             - beat acknowledge
//               bok_o             - burst OK (window hit, combinational)
//               dat_o             - read data, zero while ack_o is low
// Revision    : 1.0 - initial release
// ============================================================================
module blackwidow_bus_ram #(
    parameter int             AWID  = 32,
    parameter int             DEPTH = 4096,
    parameter logic [AWID-1:0] BASE = 32'hFFFD0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    input  logic            we_i,
    input  logic [15:0]     sel_i,
    input  logic [AWID-1:0] adr_i,
    input  logic [2:0]      cti_i,
    input  logic [1:0]      bte_i,
    input  logic [127:0]    dat_i,
    output logic            ack_o,
    output logic            bok_o,
    output logic [127:0]    dat_o
);

    localparam int ABITS = $clog2(DEPTH);

    localparam logic [2:0] c_cti_incr = 3'b010;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RACK = 3'd2,
        WACK = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ABITS-1:0]   addr_q;
    logic [ABITS-1:0]   addr_d;
    logic [127:0]       rdata_q;

    logic [127:0]       mem [DEPTH];

    logic               sel_hit;
    logic [ABITS-1:0]   widx;
    logic [ABITS-1:0]   wrap_mask;
    logic [ABITS-1:0]   addr_inc;
    logic [ABITS-1:0]   addr_next;
    logic               wr_en;
    logic               mem_we;
    logic               unused_adr_bits;

    assign unused_adr_bits = &{1'b0, adr_i[3:0]};

    assign sel_hit = cyc_i & stb_i &
                     (adr_i[AWID-1:ABITS+4] == BASE[AWID-1:ABITS+4]);
    assign widx    = adr_i[ABITS+3:4];
    assign bok_o   = sel_hit;

    // Wrapping bursts only advance the low address bits selected by the mask;
    // the linear case uses an all-ones mask and wraps modulo DEPTH naturally.
    always_comb begin
        wrap_mask = '1;
        case (bte_i)
            2'b01:   wrap_mask = ABITS'(3);
            2'b10:   wrap_mask = ABITS'(7);
            2'b11:   wrap_mask = ABITS'(15);
            default: wrap_mask = '1;
        endcase
    end

    assign addr_inc  = addr_q + ABITS'(1);
    assign addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_hit) begin
                    addr_d  = widx;
                    state_d = we_i ? WACK : RD;
                end
            end
            RD: begin
                state_d = cyc_i ? RACK : IDLE;
            end
            RACK: begin
                if (!cyc_i || !stb_i) begin
                    state_d = IDLE;
                end else if (cti_i == c_cti_incr) begin
                    addr_d = addr_next;
                end else begin
                    state_d = DONE;
                end
            end
            WACK: begin
                if (!cyc_i || !stb_i) begin
                    state_d = IDLE;
                end else begin
                    wr_en = 1'b1;
                    if (cti_i == c_cti_incr) begin
                        addr_d = addr_next;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!cyc_i || !stb_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // A beat arriving together with reset is discarded, not committed.
    assign mem_we = wr_en & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 16; b++) begin
                if (sel_i[b]) begin
                    mem[addr_q][8*b +: 8] <= dat_i[8*b +: 8];
                end
            end
        end
    end

    // Read port follows the next address so data for the upcoming beat is
    // ready exactly when RACK presents it; a word written in WACK is always
    // committed before any later RD cycle re-reads it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[addr_d];
        end
    end

    assign ack_o = (state_q == RACK) || (state_q == WACK);
    assign dat_o = (state_q == RACK) ? rdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_blackwidow_bus_ram.sv
`default_nettype none
module tb_blackwidow_bus_ram;

    logic         clk;
    logic         rst_i;
    logic         cyc_i;
    logic         stb_i;
    logic         we_i;
    logic [15:0]  sel_i;
    logic [31:0]  adr_i;
    logic [2:0]   cti_i;
    logic [1:0]   bte_i;
    logic [127:0] dat_i;
    logic         ack_o;
    logic         bok_o;
    logic [127:0] dat_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] wr_buf  [16];
    logic [127:0] rd_buf  [16];
    logic         ack_buf [16];

    blackwidow_bus_ram dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .sel_i (sel_i),
        .adr_i (adr_i),
        .cti_i (cti_i),
        .bte_i (bte_i),
        .dat_i (dat_i),
        .ack_o (ack_o),
        .bok_o (bok_o),
        .dat_o (dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = '0;
        adr_i = '0;   cti_i = 3'b000; bte_i = 2'b00; dat_i = '0;
    endtask

    // Classic write; returns ack in cycle n+1, bok during request, total acks.
    task automatic classic_write(input logic [31:0] adr, input logic [15:0] sel,
                                 input logic [127:0] data, output logic a1,
                                 output logic bok, output int total);
        tick();
        cyc_i = 1; stb_i = 1; we_i = 1; sel_i = sel; adr_i = adr;
        cti_i = 3'b000; bte_i = 2'b00; dat_i = data;
        #1; bok = bok_o; total = int'(ack_o);
        tick(); a1 = ack_o; total += int'(ack_o);
        tick(); total += int'(ack_o); idle_bus();
        tick(); total += int'(ack_o);
    endtask

    // Classic read; returns acks in n+1 / n+2, data at n+1 / n+2, total acks.
    task automatic classic_read(input logic [31:0] adr, output logic a1,
                                output logic a2, output logic [127:0] d1,
                                output logic [127:0] d2, output int total);
        tick();
        cyc_i = 1; stb_i = 1; we_i = 0; sel_i = '0; adr_i = adr;
        cti_i = 3'b000; bte_i = 2'b00;
        total = int'(ack_o);
        tick(); a1 = ack_o; d1 = dat_o; total += int'(ack_o);
        tick(); a2 = ack_o; d2 = dat_o; total += int'(ack_o);
        tick(); total += int'(ack_o); idle_bus();
        tick(); total += int'(ack_o);
    endtask

    task automatic burst_read(input logic [31:0] adr, input logic [1:0] bte,
                              input int n, output logic ack_rd, output logic ack_after);
        tick();
        cyc_i = 1; stb_i = 1; we_i = 0; sel_i = '0; adr_i = adr;
        cti_i = 3'b010; bte_i = bte;
        tick(); ack_rd = ack_o;
        for (int i = 0; i < n; i++) begin
            tick();
            ack_buf[i] = ack_o;
            rd_buf[i]  = dat_o;
            cti_i = (i == n-1) ? 3'b111 : 3'b010;
        end
        tick(); ack_after = ack_o; idle_bus();
        tick();
    endtask

    task automatic burst_write(input logic [31:0] adr, input logic [1:0] bte,
                               input int n, output logic ack_after);
        tick();
        cyc_i = 1; stb_i = 1; we_i = 1; sel_i = 16'hFFFF; adr_i = adr;
        cti_i = 3'b010; bte_i = bte;
        for (int i = 0; i < n; i++) begin
            tick();
            ack_buf[i] = ack_o;
            dat_i = wr_buf[i];
            cti_i = (i == n-1) ? 3'b111 : 3'b010;
        end
        tick(); ack_after = ack_o; idle_bus();
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle_bus();
        repeat (3) tick();
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack_o); end
        n_checks++; if (dat_o !== 128'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0", dat_o); end
        n_checks++; if (bok_o !== 1'b0) begin n_fail++; $display("FAIL reset_bok: got %b expected 0", bok_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_classic();
        logic a1, a2, bok;
        logic [127:0] d1, d2;
        int total;
        logic [127:0] pat;
        pat = 128'h0123456789ABCDEF0123456789ABCDEF;
        classic_write(32'hFFFD0010, 16'hFFFF, pat, a1, bok, total);
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL cw_bok: got %b expected 1", bok); end
        n_checks++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL cw_ack_n1: got %b expected 1", a1); end
        n_checks++; if (total !== 1) begin n_fail++; $display("FAIL cw_ack_count: got %0d expected 1", total); end
        classic_read(32'hFFFD0010, a1, a2, d1, d2, total);
        n_checks++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL cr_ack_n1: got %b expected 0", a1); end
        n_checks++; if (d1 !== 128'h0) begin n_fail++; $display("FAIL cr_dat_n1: got %h expected 0", d1); end
        n_checks++; if (a2 !== 1'b1) begin n_fail++; $display("FAIL cr_ack_n2: got %b expected 1", a2); end
        n_checks++; if (d2 !== pat) begin n_fail++; $display("FAIL cr_data: got %h expected %h", d2, pat); end
        n_checks++; if (total !== 1) begin n_fail++; $display("FAIL cr_ack_count: got %0d expected 1", total); end
    endtask

    task automatic test_byte_lanes();
        logic a1, a2, bok;
        logic [127:0] d1, d2;
        int total;
        classic_write(32'hFFFD0020, 16'hFFFF, {128{1'b1}}, a1, bok, total);
        classic_write(32'hFFFD0020, 16'h00F0, 128'h0, a1, bok, total);
        classic_read(32'hFFFD0020, a1, a2, d1, d2, total);
        n_checks++;
        if (d2 !== 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF) begin
            n_fail++;
            $display("FAIL byte_lanes: got %h expected %h", d2, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);
        end
    endtask

    task automatic test_wrap_read();
        logic a1, bok, ack_rd, ack_after;
        int total;
        logic [127:0] exp_w [4];
        for (int w = 4; w < 8; w++) begin
            classic_write(32'hFFFD0000 + 32'(w*16), 16'hFFFF, {96'hC0DE_0000_0000_0000_0000_0000, 32'(w)}, a1, bok, total);
        end
        exp_w[0] = {96'hC0DE_0000_0000_0000_0000_0000, 32'd6};
        exp_w[1] = {96'hC0DE_0000_0000_0000_0000_0000, 32'd7};
        exp_w[2] = {96'hC0DE_0000_0000_0000_0000_0000, 32'd4};
        exp_w[3] = {96'hC0DE_0000_0000_0000_0000_0000, 32'd5};
        burst_read(32'hFFFD0060, 2'b01, 4, ack_rd, ack_after);
        n_checks++; if (ack_rd !== 1'b0) begin n_fail++; $display("FAIL wrap_rd_cycle_ack: got %b expected 0", ack_rd); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (ack_buf[i] !== 1'b1) begin n_fail++; $display("FAIL wrap_ack beat %0d: got %b expected 1", i, ack_buf[i]); end
            n_checks++; if (rd_buf[i] !== exp_w[i]) begin n_fail++; $display("FAIL wrap_data beat %0d: got %h expected %h", i, rd_buf[i], exp_w[i]); end
        end
        n_checks++; if (ack_after !== 1'b0) begin n_fail++; $display("FAIL wrap_done_ack: got %b expected 0", ack_after); end
    endtask

    task automatic test_linear_wrap_write();
        logic ack_after, ack_rd;
        for (int i = 0; i < 8; i++) wr_buf[i] = {96'hA5A5_0000_0000_0000_0000_0000, 32'(i)};
        // word DEPTH-2 = 4094 -> byte offset 0xFFE0
        burst_write(32'hFFFDFFE0, 2'b00, 8, ack_after);
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (ack_buf[i] !== 1'b1) begin n_fail++; $display("FAIL lin_wr_ack beat %0d: got %b expected 1", i, ack_buf[i]); end
        end
        n_checks++; if (ack_after !== 1'b0) begin n_fail++; $display("FAIL lin_wr_done_ack: got %b expected 0", ack_after); end
        burst_read(32'hFFFDFFE0, 2'b00, 8, ack_rd, ack_after);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_buf[i] !== {96'hA5A5_0000_0000_0000_0000_0000, 32'(i)}) begin
                n_fail++;
                $display("FAIL lin_readback beat %0d: got %h expected %h", i, rd_buf[i], {96'hA5A5_0000_0000_0000_0000_0000, 32'(i)});
            end
        end
        // words 0 and 1 after the wrap land on the classic-write area; check word 1 via classic read
        begin
            logic a1, a2;
            logic [127:0] d1, d2;
            int total;
            classic_read(32'hFFFD0010, a1, a2, d1, d2, total);
            n_checks++;
            if (d2 !== {96'hA5A5_0000_0000_0000_0000_0000, 32'd3}) begin
                n_fail++; $display("FAIL lin_wrap_word1: got %h expected %h", d2, {96'hA5A5_0000_0000_0000_0000_0000, 32'd3});
            end
        end
    endtask

    task automatic test_outside_window();
        tick();
        cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 32'hFFFE0000; cti_i = 3'b000;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL outside_ack cycle %0d: got %b expected 0", i, ack_o); end
            n_checks++; if (bok_o !== 1'b0) begin n_fail++; $display("FAIL outside_bok cycle %0d: got %b expected 0", i, bok_o); end
            tick();
        end
        idle_bus();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic ack_after, ack_rd;
        logic [127:0] exp_d;
        for (int i = 0; i < 8; i++) wr_buf[i] = 128'h01D0_01D0_01D0_01D0_01D0_01D0_01D0_01D0;
        burst_write(32'hFFFD0200, 2'b00, 8, ack_after);
        for (int i = 0; i < 8; i++) wr_buf[i] = {96'hBEEF_0000_0000_0000_0000_0000, 32'(i)};
        tick();
        cyc_i = 1; stb_i = 1; we_i = 1; sel_i = 16'hFFFF; adr_i = 32'hFFFD0200;
        cti_i = 3'b010; bte_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            ack_buf[i] = ack_o;
            dat_i = wr_buf[i];
            if (i == 2) rst_i = 1'b1;
        end
        n_checks++; if (ack_buf[2] !== 1'b1) begin n_fail++; $display("FAIL rstmid_beat2_ack: got %b expected 1", ack_buf[2]); end
        tick();
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack_drop: got %b expected 0", ack_o); end
        rst_i = 1'b0;
        idle_bus();
        tick();
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_ack: got %b expected 0", ack_o); end
        burst_read(32'hFFFD0200, 2'b00, 8, ack_rd, ack_after);
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 2) ? {96'hBEEF_0000_0000_0000_0000_0000, 32'(i)}
                            : 128'h01D0_01D0_01D0_01D0_01D0_01D0_01D0_01D0;
            n_checks++; if (rd_buf[i] !== exp_d) begin n_fail++; $display("FAIL rstmid_word %0d: got %h expected %h", i, rd_buf[i], exp_d); end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        idle_bus();
        test_reset();
        test_classic();
        test_byte_lanes();
        test_wrap_read();
        test_linear_wrap_write();
        test_outside_window();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
